// File: rtl/spiker_result_sequencer.sv
// Sequences one spiker-core run: launches the core, waits for its result (with timeout),
// then streams the captured result into N_REG hw2reg words, one word per cycle.
module spiker_result_sequencer #(
  parameter int WIDTH      = 32,
  parameter int N_REG      = 24,
  parameter int DATA_WIDTH = 768,
  parameter int TIMEOUT    = 65535
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic                               clr_done_i,
  output logic                               core_start_o,
  input  logic                               core_done_i,
  input  logic [DATA_WIDTH-1:0]              core_result_i,
  output logic                               wr_en_o,
  output logic [((N_REG > 1) ? $clog2(N_REG) : 1)-1:0] wr_idx_o,
  output logic [WIDTH-1:0]                   wr_data_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               error_o
);

  localparam int IW = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REG - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_WRITE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           idx_nxt;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    core_start_q, core_start_d;
  logic                    wr_en_q, wr_en_d;
  logic [IW-1:0]           wr_idx_q, wr_idx_d;
  logic [WIDTH-1:0]        wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  // Next-state and registered-output computation; write outputs are pre-computed one cycle ahead.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    core_start_d = 1'b0;
    wr_en_d      = 1'b0;
    wr_idx_d     = {IW{1'b0}};
    wr_data_d    = {WIDTH{1'b0}};
    error_d      = error_q;
    idx_nxt      = idx_q + IW'(1);

    if (clr_done_i) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d      = S_LAUNCH;
          core_start_d = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        cnt_d   = {CW{1'b0}};
        state_d = S_RUN;
      end
      S_RUN: begin
        // A completion on the timeout cycle still counts as success.
        if (core_done_i) begin
          hold_d    = core_result_i;
          idx_d     = {IW{1'b0}};
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_idx_d  = {IW{1'b0}};
          wr_data_d = core_result_i[WIDTH-1:0];
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d     = idx_nxt;
          wr_en_d   = 1'b1;
          wr_idx_d  = idx_nxt;
          wr_data_d = hold_q[int'(idx_nxt)*WIDTH +: WIDTH];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      idx_q        <= {IW{1'b0}};
      hold_q       <= {DATA_WIDTH{1'b0}};
      core_start_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= {IW{1'b0}};
      wr_data_q    <= {WIDTH{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      core_start_q <= core_start_d;
      wr_en_q      <= wr_en_d;
      wr_idx_q     <= wr_idx_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign core_start_o = core_start_q;
  assign wr_en_o      = wr_en_q;
  assign wr_idx_o     = wr_idx_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_spiker_result_sequencer.sv
// Directed bench for spiker_result_sequencer: normal run, back-to-back, timeout,
// done/timeout coincidence, ignored inputs and reset during the write burst.
module tb_spiker_result_sequencer;

  localparam int W  = 32;
  localparam int NR = 24;
  localparam int DW = 768;
  localparam int TO = 16;

  logic          clk;
  logic          rst_ni;
  logic          start_i;
  logic          clr_done_i;
  logic          core_start_o;
  logic          core_done_i;
  logic [DW-1:0] core_result_i;
  logic          wr_en_o;
  logic [4:0]    wr_idx_o;
  logic [W-1:0]  wr_data_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  int checks;
  int errors;

  logic [DW-1:0] ra, rb, rc, rd, re;

  spiker_result_sequencer #(
    .WIDTH(W), .N_REG(NR), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .clr_done_i(clr_done_i),
    .core_start_o(core_start_o), .core_done_i(core_done_i), .core_result_i(core_result_i),
    .wr_en_o(wr_en_o), .wr_idx_o(wr_idx_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept a start from IDLE; returns in the first RUN cycle.
  task automatic start_run(input string tag);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({tag, "_launch_pulse"}, 64'(core_start_o), 64'd1);
    chk({tag, "_launch_busy"}, 64'(busy_o), 64'd1);
    chk({tag, "_launch_done"}, 64'(done_o), 64'd0);
    chk({tag, "_launch_err"}, 64'(error_o), 64'd0);
    tick();
    chk({tag, "_pulse_one_cycle"}, 64'(core_start_o), 64'd0);
    chk({tag, "_run_busy"}, 64'(busy_o), 64'd1);
  endtask

  // Deliver the core result in the current RUN cycle.
  task automatic deliver(input logic [DW-1:0] r);
    core_done_i   = 1'b1;
    core_result_i = r;
    tick();
    core_done_i   = 1'b0;
    core_result_i = '0;
  endtask

  // Check the full strobe burst; optionally disturb at one index and clear done on the last.
  task automatic write_seq(input string tag, input logic [DW-1:0] r, input int disturb_at,
                           input bit clr_last);
    for (int k = 0; k < NR; k++) begin
      chk({tag, "_wr_en"}, 64'(wr_en_o), 64'd1);
      chk({tag, "_wr_idx"}, 64'(wr_idx_o), 64'(k));
      chk({tag, "_wr_data"}, 64'(wr_data_o), 64'(r[k*W +: W]));
      chk({tag, "_no_relaunch"}, 64'(core_start_o), 64'd0);
      chk({tag, "_wr_busy"}, 64'(busy_o), 64'd1);
      if (k == disturb_at) begin
        start_i       = 1'b1;
        core_done_i   = 1'b1;
        core_result_i = ~r;
      end
      if (clr_last && k == NR - 1) clr_done_i = 1'b1;
      tick();
      start_i       = 1'b0;
      core_done_i   = 1'b0;
      core_result_i = '0;
      clr_done_i    = 1'b0;
    end
    chk({tag, "_end_wr_en"}, 64'(wr_en_o), 64'd0);
    chk({tag, "_end_wr_idx"}, 64'(wr_idx_o), 64'd0);
    chk({tag, "_end_wr_data"}, 64'(wr_data_o), 64'd0);
    chk({tag, "_end_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_end_done"}, 64'(done_o), 64'd1);
    chk({tag, "_end_launch"}, 64'(core_start_o), 64'd0);
  endtask

  initial begin
    int n;
    checks        = 0;
    errors        = 0;
    rst_ni        = 1'b0;
    start_i       = 1'b0;
    clr_done_i    = 1'b0;
    core_done_i   = 1'b0;
    core_result_i = '0;
    for (int k = 0; k < NR; k++) begin
      ra[k*W +: W] = 32'hA000_0000 + 32'(k);
      rb[k*W +: W] = 32'h5A5A_0000 ^ 32'(k);
      rc[k*W +: W] = 32'hC0DE_0000 + 32'(k * 257);
      rd[k*W +: W] = 32'h1234_5678 + 32'(k * 16);
      re[k*W +: W] = 32'hFFFF_0000 - 32'(k);
    end

    // Reset state
    #12;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(error_o), 64'd0);
    chk("rst_wr_en", 64'(wr_en_o), 64'd0);
    chk("rst_launch", 64'(core_start_o), 64'd0);

    // Normal run: release and start in cycle 0, core done in cycle 10
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    start_run("norm");
    n = 0;
    repeat (8) begin
      if (wr_en_o) n++;
      tick();
    end
    chk("norm_no_strobe_in_run", 64'(n), 64'd0);
    deliver(ra);
    write_seq("norm", ra, -1, 1'b0);

    // Back-to-back: start on the first done cycle
    start_run("b2b");
    repeat (3) tick();
    deliver(rb);
    write_seq("b2b", rb, -1, 1'b0);

    // Timeout after 16 RUN cycles
    start_run("to");
    n = 0;
    repeat (TO - 1) begin
      if (wr_en_o) n++;
      tick();
    end
    chk("to_last_run_busy", 64'(busy_o), 64'd1);
    chk("to_last_run_err", 64'(error_o), 64'd0);
    if (wr_en_o) n++;
    tick();
    chk("to_err", 64'(error_o), 64'd1);
    chk("to_busy", 64'(busy_o), 64'd0);
    chk("to_done", 64'(done_o), 64'd0);
    repeat (3) begin
      if (wr_en_o) n++;
      tick();
    end
    chk("to_no_strobes", 64'(n), 64'd0);
    clr_done_i = 1'b1;
    tick();
    clr_done_i = 1'b0;
    chk("to_err_sticky", 64'(error_o), 64'd1);

    // Done on the timeout cycle wins; clr_done on the set cycle loses
    start_run("coin");
    repeat (TO - 1) tick();
    deliver(rc);
    write_seq("coin", rc, -1, 1'b1);
    chk("coin_err", 64'(error_o), 64'd0);
    clr_done_i = 1'b1;
    tick();
    clr_done_i = 1'b0;
    chk("clr_done", 64'(done_o), 64'd0);

    // Ignored inputs: core_done in IDLE, start and core_done during WRITE
    core_done_i   = 1'b1;
    core_result_i = re;
    tick();
    core_done_i   = 1'b0;
    core_result_i = '0;
    chk("idle_done_busy", 64'(busy_o), 64'd0);
    chk("idle_done_wr_en", 64'(wr_en_o), 64'd0);
    chk("idle_done_launch", 64'(core_start_o), 64'd0);
    tick();
    start_run("ign");
    repeat (4) tick();
    deliver(rd);
    write_seq("ign", rd, 9, 1'b0);

    // Reset in the middle of the write burst
    start_run("mrst");
    repeat (2) tick();
    deliver(rc);
    for (int k = 0; k < 7; k++) tick();
    chk("mrst_idx7", 64'(wr_idx_o), 64'd7);
    chk("mrst_en7", 64'(wr_en_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mrst_wr_en", 64'(wr_en_o), 64'd0);
    chk("mrst_wr_idx", 64'(wr_idx_o), 64'd0);
    chk("mrst_wr_data", 64'(wr_data_o), 64'd0);
    chk("mrst_busy", 64'(busy_o), 64'd0);
    chk("mrst_done", 64'(done_o), 64'd0);
    chk("mrst_err", 64'(error_o), 64'd0);
    chk("mrst_launch", 64'(core_start_o), 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    n = 0;
    repeat (30) begin
      if (wr_en_o || busy_o) n++;
      tick();
    end
    chk("mrst_quiet_after_release", 64'(n), 64'd0);
    start_run("post");
    repeat (5) tick();
    deliver(re);
    write_seq("post", re, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spiker_result_sequencer.md
SPIKER_RESULT_SEQUENCER -- requirements
Module: spiker_result_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the register word width in bits.
REQ-002 The block SHALL have parameter N_REG, default 24, meaning the number of result registers.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 768 (= WIDTH*N_REG), meaning the core result width in bits.
REQ-004 The block SHALL have parameter TIMEOUT, default 65535, meaning the maximum number of RUN cycles before an error.
REQ-005 The block SHALL have port clk_i  in  1  the single clock.
REQ-006 The block SHALL have port rst_ni  in  1  the reset, asynchronous and active-low.
REQ-007 The block SHALL have port start_i  in  1  the software start pulse.
REQ-008 The block SHALL have port clr_done_i  in  1  the software clear for done_o.
REQ-009 The block SHALL have port core_start_o  out  1  the one-cycle launch pulse to the spiker core.
REQ-010 The block SHALL have port core_done_i  in  1  the core completion pulse; core_result_i is valid in the same cycle.
REQ-011 The block SHALL have port core_result_i  in  DATA_WIDTH  the core result vector.
REQ-012 The block SHALL have port wr_en_o  out  1  the hw2reg data-enable strobe.
REQ-013 The block SHALL have port wr_idx_o  out  $clog2(N_REG)  the target spikes_result register index.
REQ-014 The block SHALL have port wr_data_o  out  WIDTH  the word to write.
REQ-015 The block SHALL have port busy_o, done_o and error_o  out  1 each  the status flags.

Function
REQ-016 The FSM SHALL have the states IDLE, LAUNCH, RUN and WRITE.
REQ-017 In IDLE, start_i=1 SHALL cause a transition to LAUNCH next cycle and SHALL clear done_o and error_o.
REQ-018 In states other than IDLE, start_i SHALL be ignored.
REQ-019 In LAUNCH, core_start_o SHALL be 1 for exactly that cycle, the timeout counter SHALL be zeroed, and the FSM SHALL go to RUN unconditionally.
REQ-020 In RUN, core_done_i=1 SHALL capture core_result_i into an internal DATA_WIDTH hold register, set the index to 0, and go to WRITE.
REQ-021 In RUN without core_done_i, the counter SHALL increment; when the counter equals TIMEOUT-1, the block SHALL set error_o (sticky), return to IDLE, and make no writes.
REQ-022 When core_done_i and the timeout occur in the same cycle, done SHALL win (capture, no error).
REQ-023 core_done_i outside RUN SHALL be ignored, and the hold register SHALL be unchanged.
REQ-024 In WRITE, every cycle SHALL drive wr_en_o=1, wr_idx_o=idx, and wr_data_o=hold[idx*WIDTH +: WIDTH]; idx SHALL increment by 1.
REQ-025 When idx=N_REG-1 is written, the FSM SHALL return to IDLE and set done_o next cycle; there SHALL be exactly N_REG strobes, with no gaps and no wrap to index 0.
REQ-026 The first wr_en_o SHALL occur the cycle after core_done_i, and the last one N_REG cycles after core_done_i.
REQ-027 Outside WRITE, wr_en_o SHALL be 0 and wr_idx_o/wr_data_o SHALL be 0.
REQ-028 busy_o SHALL be 1 iff the state is not IDLE.
REQ-029 done_o SHALL stay at 1 until clr_done_i or an accepted start_i; if a set and clr_done_i coincide, set SHALL win.
REQ-030 error_o SHALL be cleared only by an accepted start_i or by reset.
REQ-031 The counter width SHALL be $clog2(TIMEOUT+1), and the counter SHALL never wrap in RUN.

Reset
REQ-032 rst_ni=0 SHALL, asynchronously and in any state, force IDLE and set core_start_o, wr_en_o, wr_idx_o, wr_data_o, busy_o, done_o and error_o to 0, with idx, counter and hold all 0.
REQ-033 Reset in the middle of WRITE SHALL abort the remaining strobes, and after release no strobe SHALL occur until a new start_i.
REQ-034 Deassertion of rst_ni SHALL take effect synchronously to clk_i; the first start_i SHALL be honoured on the first active edge after release.

Verification
REQ-035 The bench SHALL cover: normal run — start_i at cycle 0 -> core_start_o at cycle 1; core_done_i at cycle 10 with word k = 32'hA000_0000+k -> wr_en_o cycles 11..34, idx 0..23, data A000_0000..A000_0017; done_o=1 from cycle 35, busy_o=0.
REQ-036 The bench SHALL cover: timeout — set TIMEOUT=16, start_i and never core_done_i -> error_o=1 and busy_o=0 after 16 RUN cycles; zero wr_en_o strobes.
REQ-037 The bench SHALL cover: coincidence — core_done_i on the timeout cycle -> 24 strobes and error_o=0; clr_done_i on the done-set cycle -> done_o=1.
REQ-038 The bench SHALL cover: ignored inputs — start_i during WRITE and core_done_i during IDLE -> no second launch, strobe sequence unchanged, hold register unchanged.
REQ-039 The bench SHALL cover: reset mid-WRITE — rst_ni=0 at idx=7 -> all outputs 0 immediately; after release no strobes; a new start_i gives a full 24-strobe sequence.
REQ-040 The bench SHALL cover: back-to-back — start_i the cycle after done_o sets -> done_o clears, second run completes, done_o=1 again.
